// File: rtl/ofdm_tx_pkg.sv
// Shared widths and helpers for the OFDM VLC transmit chain.
// Used by the frame serializer and the constellation mapper.
package ofdm_tx_pkg;

  localparam int FRAME_W_DEF = 224;
  localparam int OUT_W_DEF   = 1;

  function automatic int nchunk(input int fw, input int ow);
    return fw / ow;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NCHUNK_DEF = nchunk(FRAME_W_DEF, OUT_W_DEF);
  localparam int CNT_W_DEF  = idx_w(NCHUNK_DEF);

endpackage

// File: rtl/ofdm_tx_slot_ram.sv
// DEPTH x FRAME_W frame store: one write port, async chunk read.
// OFDM_TXBUF_MSB_FIRST_EN selects MSB-first chunk order.
module ofdm_tx_slot_ram
  import ofdm_tx_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int DEPTH   = 2,
  localparam int NCHUNK = nchunk(FRAME_W, OUT_W),
  localparam int CW     = idx_w(NCHUNK),
  localparam int PW     = idx_w(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PW-1:0]      waddr,
  input  logic [FRAME_W-1:0] wdata,
  input  logic [PW-1:0]      raddr,
  input  logic [CW-1:0]      rchunk,
  output logic [OUT_W-1:0]   rdata
);

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [FRAME_W-1:0] word;

  // Frame write; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Select the current chunk of the slot being read.
  always_comb begin
    word = mem[raddr];
`ifdef OFDM_TXBUF_MSB_FIRST_EN
    rdata = word[FRAME_W-1-int'(rchunk)*OUT_W -: OUT_W];
`else
    rdata = word[int'(rchunk)*OUT_W +: OUT_W];
`endif
  end

endmodule

// File: rtl/ofdm_tx_frame_serializer.sv
// Frame buffer: whole frames in, OUT_W-bit chunks out.
// OFDM_TXBUF_MSB_FIRST_EN selects MSB-first chunk order.
module ofdm_tx_frame_serializer
  import ofdm_tx_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int DEPTH   = 2,
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [FRAME_W-1:0] din,
  input  logic               din_valid,
  output logic               din_wready,
  output logic [OUT_W-1:0]   dout,
  output logic               dout_valid,
  input  logic               dout_rready,
  output logic               dout_last,
  output logic [LW-1:0]      level
);

  localparam int NCHUNK = nchunk(FRAME_W, OUT_W);
  localparam int CW     = idx_w(NCHUNK);
  localparam int PW     = idx_w(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [LW-1:0]    lvl;
  logic             up;
  logic             full;
  logic             at_last;
  logic             wr_fire;
  logic             rd_fire;
  logic             rd_done;
  logic [OUT_W-1:0] chunk;

  assign full       = (lvl == LW'(DEPTH));
  assign at_last    = (cnt == CW'(NCHUNK - 1));
  assign din_wready = up && !full;
  assign dout_valid = (lvl != '0);
  assign dout_last  = dout_valid && at_last;
  assign dout       = dout_valid ? chunk : '0;
  assign level      = lvl;

  assign wr_fire = din_valid && din_wready;
  assign rd_fire = dout_valid && dout_rready;
  assign rd_done = rd_fire && at_last;

  ofdm_tx_slot_ram #(
    .FRAME_W (FRAME_W),
    .OUT_W   (OUT_W),
    .DEPTH   (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (wr_fire),
    .waddr  (wr_ptr),
    .wdata  (din),
    .raddr  (rd_ptr),
    .rchunk (cnt),
    .rdata  (chunk)
  );

  // Ready is held off until the first edge after reset release.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) up <= 1'b0;
    else         up <= 1'b1;
  end

  // Write pointer advances on each accepted frame.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)      wr_ptr <= '0;
    else if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
  end

  // Chunk counter and read pointer; frame retires on its last chunk.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt    <= '0;
      rd_ptr <= '0;
    end else if (rd_fire) begin
      if (at_last) begin
        cnt    <= '0;
        rd_ptr <= rd_ptr + PW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Occupancy: write and frame-completing read cancel out.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lvl <= '0;
    end else begin
      unique case (1'b1)
        (wr_fire && !rd_done): lvl <= lvl + LW'(1);
        (!wr_fire && rd_done): lvl <= lvl - LW'(1);
        default:               lvl <= lvl;
      endcase
    end
  end

endmodule

// File: tb/tb_ofdm_tx_frame_serializer.sv
// Directed bench for ofdm_tx_frame_serializer.
// Honours OFDM_TXBUF_MSB_FIRST_EN for expected chunk order.
module tb_ofdm_tx_frame_serializer;

  logic         clk = 1'b0;
  logic         nreset;

  logic [223:0] din;
  logic         din_valid;
  logic         din_wready;
  logic [0:0]   dout;
  logic         dout_valid;
  logic         dout_rready;
  logic         dout_last;
  logic [1:0]   level;

  logic [223:0] din4;
  logic         din_valid4;
  logic         din_wready4;
  logic [3:0]   dout4;
  logic         dout_valid4;
  logic         dout_rready4;
  logic         dout_last4;
  logic [1:0]   level4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ofdm_tx_frame_serializer #(
    .FRAME_W (224),
    .OUT_W   (1),
    .DEPTH   (2)
  ) u_dut (
    .clk         (clk),
    .nreset      (nreset),
    .din         (din),
    .din_valid   (din_valid),
    .din_wready  (din_wready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_rready (dout_rready),
    .dout_last   (dout_last),
    .level       (level)
  );

  ofdm_tx_frame_serializer #(
    .FRAME_W (224),
    .OUT_W   (4),
    .DEPTH   (2)
  ) u_dut4 (
    .clk         (clk),
    .nreset      (nreset),
    .din         (din4),
    .din_valid   (din_valid4),
    .din_wready  (din_wready4),
    .dout        (dout4),
    .dout_valid  (dout_valid4),
    .dout_rready (dout_rready4),
    .dout_last   (dout_last4),
    .level       (level4)
  );

  function automatic logic exp1(input logic [223:0] f, input int i);
`ifdef OFDM_TXBUF_MSB_FIRST_EN
    return f[223-i];
`else
    return f[i];
`endif
  endfunction

  function automatic logic [3:0] exp4(input logic [223:0] f, input int k);
`ifdef OFDM_TXBUF_MSB_FIRST_EN
    return f[223-4*k -: 4];
`else
    return f[4*k +: 4];
`endif
  endfunction

  task automatic test_reset();
    nreset = 1'b0;
    din = '0; din_valid = 1'b0; dout_rready = 1'b0;
    din4 = '0; din_valid4 = 1'b0; dout_rready4 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({din_wready, dout_valid, dout_last, level, dout} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outs got=%b want=000000",
               {din_wready, dout_valid, dout_last, level, dout});
    end
    checks++;
    if ({din_wready4, dout_valid4, dout_last4, level4, dout4} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outs4 got=%b want=0",
               {din_wready4, dout_valid4, dout_last4, level4, dout4});
    end
    nreset = 1'b1;
    @(negedge clk);
    checks++;
    if ({din_wready, din_wready4} !== 2'b11) begin
      failures++;
      $display("FAIL reset_ready got=%b want=11", {din_wready, din_wready4});
    end
  endtask

  task automatic test_single();
    logic [223:0] f;
    int errs;
    f = 224'h1;
    errs = 0;
    din = f; din_valid = 1'b1; dout_rready = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if (level !== 2'd1) begin
      failures++;
      $display("FAIL single_level1 got=%0d want=1", level);
    end
    for (int i = 0; i < 224; i++) begin
      if ({dout_valid, dout, dout_last} !== {1'b1, exp1(f, i), i == 223})
        begin
        errs++;
        if (errs < 4)
          $display("FAIL single_beat%0d got=%b want=%b", i,
                   {dout_valid, dout, dout_last}, {1'b1, exp1(f, i), i == 223});
      end
      @(negedge clk);
    end
    checks++;
    if (errs !== 0) begin
      failures++;
      $display("FAIL single_stream bad_beats=%0d want=0", errs);
    end
    checks++;
    if ({level, dout_valid} !== 3'b000) begin
      failures++;
      $display("FAIL single_drained got=%b want=000", {level, dout_valid});
    end
    dout_rready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [223:0] fr [3];
    int fi, beat, cacc, errs, rerr;
    logic wr;
    fr[0] = {7{32'hDEADBEEF}};
    fr[1] = {7{32'h0F1E2D3C}};
    fr[2] = {7{32'h12345678}};
    fi = 0; beat = 0; cacc = -1; errs = 0; rerr = 0;
    dout_rready = 1'b1; din = fr[0]; din_valid = 1'b1;
    for (int t = 0; t <= 672; t++) begin
      wr = din_valid && din_wready;
      if (wr && fi == 2) cacc = t;
      @(negedge clk);
      if (wr) begin
        fi++;
        if (fi < 3) din = fr[fi];
        else din_valid = 1'b0;
      end
      if (beat < 672) begin
        if ({dout_valid, dout, dout_last} !==
            {1'b1, exp1(fr[beat/224], beat % 224), (beat % 224) == 223}) begin
          errs++;
          if (errs < 4)
            $display("FAIL b2b_beat%0d got=%b", beat,
                     {dout_valid, dout, dout_last});
        end
        beat++;
      end else if (dout_valid !== 1'b0) begin
        errs++;
        $display("FAIL b2b_tail got_valid=%b want=0", dout_valid);
      end
      if (din_wready !== (level != 2'd2)) rerr++;
    end
    checks++;
    if (errs !== 0) begin
      failures++;
      $display("FAIL b2b_stream bad_beats=%0d want=0", errs);
    end
    checks++;
    if (rerr !== 0) begin
      failures++;
      $display("FAIL b2b_ready bad_cycles=%0d want=0", rerr);
    end
    checks++;
    if (cacc !== 225) begin
      failures++;
      $display("FAIL b2b_third_accept got=%0d want=225", cacc);
    end
    checks++;
    if (fi !== 3) begin
      failures++;
      $display("FAIL b2b_accepted got=%0d want=3", fi);
    end
    dout_rready = 1'b0;
  endtask

  task automatic test_full_boundary();
    logic [223:0] fd, fe, ff;
    int n, errs;
    logic e;
    fd = {7{32'hCAFEF00D}};
    fe = {7{32'h13579BDF}};
    ff = {7{32'h2468ACE0}};
    dout_rready = 1'b0;
    din = fd; din_valid = 1'b1;
    @(negedge clk);
    din = fe;
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if ({level, din_wready, dout} !== {2'd2, 1'b0, exp1(fd, 0)}) begin
      failures++;
      $display("FAIL full_fill got=%b want=%b",
               {level, din_wready, dout}, {2'd2, 1'b0, exp1(fd, 0)});
    end
    dout_rready = 1'b1;
    repeat (223) @(negedge clk);
    din = ff; din_valid = 1'b1;
    checks++;
    if ({dout_last, level, din_wready} !== {1'b1, 2'd2, 1'b0}) begin
      failures++;
      $display("FAIL full_T got=%b want=1100",
               {dout_last, level, din_wready});
    end
    @(negedge clk);
    checks++;
    if ({level, din_wready} !== {2'd1, 1'b1}) begin
      failures++;
      $display("FAIL full_T1 got=%b want=011", {level, din_wready});
    end
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if ({level, din_wready, dout} !== {2'd2, 1'b0, exp1(fe, 1)}) begin
      failures++;
      $display("FAIL full_T2 got=%b want=%b",
               {level, din_wready, dout}, {2'd2, 1'b0, exp1(fe, 1)});
    end
    n = 0; errs = 0;
    while (dout_valid && n < 1000) begin
      e = (n < 223) ? exp1(fe, n + 1) : exp1(ff, n - 223);
      if (dout !== e) errs++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 447) begin
      failures++;
      $display("FAIL full_drain_len got=%0d want=447", n);
    end
    checks++;
    if (errs !== 0) begin
      failures++;
      $display("FAIL full_drain_data bad_beats=%0d want=0", errs);
    end
    dout_rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [223:0] fg, fh;
    int errs;
    fg = {7{32'h5A5AC33C}};
    fh = {7{32'h89ABCDEF}};
    dout_rready = 1'b1;
    din = fg; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if ({dout_valid, dout} !== {1'b1, exp1(fg, 100)}) begin
      failures++;
      $display("FAIL mid_chunk100 got=%b want=%b",
               {dout_valid, dout}, {1'b1, exp1(fg, 100)});
    end
    #2 nreset = 1'b0;
    #1;
    checks++;
    if ({din_wready, dout_valid, dout_last, level, dout} !== 6'b0) begin
      failures++;
      $display("FAIL mid_async_reset got=%b want=000000",
               {din_wready, dout_valid, dout_last, level, dout});
    end
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    din = fh; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    errs = 0;
    for (int i = 0; i < 224; i++) begin
      if ({dout_valid, dout, dout_last} !== {1'b1, exp1(fh, i), i == 223})
        errs++;
      @(negedge clk);
    end
    checks++;
    if (errs !== 0) begin
      failures++;
      $display("FAIL mid_next_frame bad_beats=%0d want=0", errs);
    end
    checks++;
    if ({level, dout_valid} !== 3'b000) begin
      failures++;
      $display("FAIL mid_drained got=%b want=000", {level, dout_valid});
    end
    dout_rready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [223:0] fp;
    logic [3:0] prev_d;
    logic prev_stall, r;
    int k, serr, derr;
    fp = {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210,
          32'h13579BDF, 32'h02468ACE, 32'hA5C3E1F0};
    k = 0; serr = 0; derr = 0; prev_stall = 1'b0; prev_d = '0;
    din4 = fp; din_valid4 = 1'b1;
    @(negedge clk);
    din_valid4 = 1'b0;
    for (int t = 0; t < 400 && k < 56; t++) begin
      r = 1'($urandom_range(0, 1));
      if (prev_stall && {dout_valid4, dout4} !== {1'b1, prev_d}) serr++;
      dout_rready4 = r;
      if (dout_valid4 && r) begin
        if ({dout4, dout_last4} !== {exp4(fp, k), k == 55}) begin
          derr++;
          if (derr < 4)
            $display("FAIL bp_nibble%0d got=%h want=%h", k, dout4,
                     exp4(fp, k));
        end
        k++;
      end
      prev_stall = dout_valid4 && !r;
      prev_d = dout4;
      @(negedge clk);
    end
    dout_rready4 = 1'b0;
    checks++;
    if (k !== 56) begin
      failures++;
      $display("FAIL bp_count got=%0d want=56", k);
    end
    checks++;
    if (derr !== 0) begin
      failures++;
      $display("FAIL bp_data bad_nibbles=%0d want=0", derr);
    end
    checks++;
    if (serr !== 0) begin
      failures++;
      $display("FAIL bp_stall_hold bad_cycles=%0d want=0", serr);
    end
    checks++;
    if ({level4, dout_valid4} !== 3'b000) begin
      failures++;
      $display("FAIL bp_drained got=%b want=000", {level4, dout_valid4});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_boundary();
    test_reset_mid();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
